// File: rtl/reg_timeout_pkg.sv
// Shared definitions for the register-bus source-side watchdog.
//   state_e           : watchdog FSM states (FWD, DRAIN)
//   ERR_RDATA_DEFAULT : read pattern returned on a timed-out access
//   cnt_width()       : width of a counter that must hold 0..timeout
package reg_timeout_pkg;

  typedef enum logic [0:0] {
    FWD   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADCAB1E;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/reg_timeout_hold.sv
// Request hold register bank with load enable and asynchronous clear.
// Ports:
//   src_clk_i  : clock
//   src_rst_ni : asynchronous active-low reset, clears q to 0
//   load       : capture d on the next rising edge
//   d          : data to capture
//   q          : held data
module reg_timeout_hold #(
  parameter int W = 8
) (
  input  logic         src_clk_i,
  input  logic         src_rst_ni,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_timeout_src.sv
// Register-bus watchdog in the source clock domain, upstream of the CDC
// source side. Requests pass through combinationally. If the downstream
// target has not completed after TIMEOUT waiting cycles, the upstream
// access is completed with an error and ERR_RDATA; the orphaned request is
// then held on the downstream side until its late response arrives, and
// that response is dropped.
//
// Ports:
//   src_clk_i, src_rst_ni : clock, asynchronous active-low reset
//   up_*                  : upstream request in / response out
//   dn_*                  : downstream (CDC) request out / response in
//   timeout_o             : one-cycle pulse on each timeout completion
// Optional (macro REG_TIMEOUT_STATUS_EN):
//   timeout_cnt_o         : saturating count of timeouts
//   timeout_addr_o        : address of the most recent timed-out request
module reg_timeout_src
  import reg_timeout_pkg::*;
#(
  parameter int          AW        = 32,
  parameter int          DW        = 32,
  parameter int          TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
  input  logic            src_clk_i,
  input  logic            src_rst_ni,
  input  logic            up_valid_i,
  input  logic            up_write_i,
  input  logic [AW-1:0]   up_addr_i,
  input  logic [DW-1:0]   up_wdata_i,
  input  logic [DW/8-1:0] up_wstrb_i,
  output logic [DW-1:0]   up_rdata_o,
  output logic            up_error_o,
  output logic            up_ready_o,
  output logic            dn_valid_o,
  output logic            dn_write_o,
  output logic [AW-1:0]   dn_addr_o,
  output logic [DW-1:0]   dn_wdata_o,
  output logic [DW/8-1:0] dn_wstrb_o,
  input  logic [DW-1:0]   dn_rdata_i,
  input  logic            dn_error_i,
  input  logic            dn_ready_i,
  output logic            timeout_o
`ifdef REG_TIMEOUT_STATUS_EN
  ,
  output logic [15:0]     timeout_cnt_o,
  output logic [AW-1:0]   timeout_addr_o
`endif
);

  localparam logic [0:0]    S_FWD   = FWD;
  localparam logic [0:0]    S_DRAIN = DRAIN;
  localparam int            CW      = cnt_width(TIMEOUT);
  localparam int            HW      = 1 + AW + DW + DW / 8;
  localparam logic [DW-1:0] ERR_DW  = DW'(ERR_RDATA);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  logic [0:0]    state_q;
  logic [CW-1:0] cnt_q;
  logic          waiting;
  logic          timeout_hit;

  logic          hold_write;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic [DW/8-1:0] hold_wstrb;

  // A dn_ready_i in the final waiting cycle counts as a normal completion,
  // so the timeout only fires while the target is still not ready.
  assign waiting     = up_valid_i & ~dn_ready_i;
  assign timeout_hit = (state_q == S_FWD) & waiting & (cnt_q == CNT_MAX);
  assign timeout_o   = timeout_hit;

  reg_timeout_hold #(
    .W (HW)
  ) u_hold_req (
    .src_clk_i  (src_clk_i),
    .src_rst_ni (src_rst_ni),
    .load       (timeout_hit),
    .d          ({up_write_i, up_addr_i, up_wdata_i, up_wstrb_i}),
    .q          ({hold_write, hold_addr, hold_wdata, hold_wstrb})
  );

  // In DRAIN the downstream side keeps seeing the orphaned request unchanged
  // so the CDC handshake stays legal; upstream is stalled meanwhile.
  always_comb begin
    dn_valid_o = up_valid_i;
    dn_write_o = up_write_i;
    dn_addr_o  = up_addr_i;
    dn_wdata_o = up_wdata_i;
    dn_wstrb_o = up_wstrb_i;
    up_ready_o = dn_ready_i;
    up_error_o = dn_error_i;
    up_rdata_o = dn_rdata_i;
    if (state_q == S_DRAIN) begin
      dn_valid_o = 1'b1;
      dn_write_o = hold_write;
      dn_addr_o  = hold_addr;
      dn_wdata_o = hold_wdata;
      dn_wstrb_o = hold_wstrb;
      up_ready_o = 1'b0;
      up_error_o = 1'b0;
      up_rdata_o = '0;
    end else if (timeout_hit) begin
      up_ready_o = 1'b1;
      up_error_o = 1'b1;
      up_rdata_o = ERR_DW;
    end
  end

  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      state_q <= S_FWD;
      cnt_q   <= '0;
    end else if (state_q == S_FWD) begin
      if (timeout_hit) begin
        state_q <= S_DRAIN;
        cnt_q   <= '0;
      end else if (waiting) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
    end else begin
      cnt_q <= '0;
      if (dn_ready_i) begin
        state_q <= S_FWD;
      end
    end
  end

`ifdef REG_TIMEOUT_STATUS_EN
  logic [15:0] timeout_cnt_q;

  always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
    if (!src_rst_ni) begin
      timeout_cnt_q <= '0;
    end else if (timeout_hit && (timeout_cnt_q != 16'hFFFF)) begin
      timeout_cnt_q <= timeout_cnt_q + 16'd1;
    end
  end

  assign timeout_cnt_o = timeout_cnt_q;

  reg_timeout_hold #(
    .W (AW)
  ) u_hold_status_addr (
    .src_clk_i  (src_clk_i),
    .src_rst_ni (src_rst_ni),
    .load       (timeout_hit),
    .d          (up_addr_i),
    .q          (timeout_addr_o)
  );
`endif

endmodule

// File: tb/tb_reg_timeout_src.sv
// Directed testbench for reg_timeout_src with TIMEOUT = 4. Inputs change
// 1 time unit after the rising edge; outputs are sampled mid-cycle.
module tb_reg_timeout_src;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic            src_clk_i;
  logic            src_rst_ni;
  logic            up_valid_i;
  logic            up_write_i;
  logic [AW-1:0]   up_addr_i;
  logic [DW-1:0]   up_wdata_i;
  logic [DW/8-1:0] up_wstrb_i;
  logic [DW-1:0]   up_rdata_o;
  logic            up_error_o;
  logic            up_ready_o;
  logic            dn_valid_o;
  logic            dn_write_o;
  logic [AW-1:0]   dn_addr_o;
  logic [DW-1:0]   dn_wdata_o;
  logic [DW/8-1:0] dn_wstrb_o;
  logic [DW-1:0]   dn_rdata_i;
  logic            dn_error_i;
  logic            dn_ready_i;
  logic            timeout_o;
`ifdef REG_TIMEOUT_STATUS_EN
  logic [15:0]     timeout_cnt_o;
  logic [AW-1:0]   timeout_addr_o;
`endif

  int n_total = 0;
  int n_pass  = 0;

  reg_timeout_src #(
    .AW        (AW),
    .DW        (DW),
    .TIMEOUT   (TO),
    .ERR_RDATA (32'hBADCAB1E)
  ) dut (
    .src_clk_i  (src_clk_i),
    .src_rst_ni (src_rst_ni),
    .up_valid_i (up_valid_i),
    .up_write_i (up_write_i),
    .up_addr_i  (up_addr_i),
    .up_wdata_i (up_wdata_i),
    .up_wstrb_i (up_wstrb_i),
    .up_rdata_o (up_rdata_o),
    .up_error_o (up_error_o),
    .up_ready_o (up_ready_o),
    .dn_valid_o (dn_valid_o),
    .dn_write_o (dn_write_o),
    .dn_addr_o  (dn_addr_o),
    .dn_wdata_o (dn_wdata_o),
    .dn_wstrb_o (dn_wstrb_o),
    .dn_rdata_i (dn_rdata_i),
    .dn_error_i (dn_error_i),
    .dn_ready_i (dn_ready_i),
    .timeout_o  (timeout_o)
`ifdef REG_TIMEOUT_STATUS_EN
    ,
    .timeout_cnt_o  (timeout_cnt_o),
    .timeout_addr_o (timeout_addr_o)
`endif
  );

  initial src_clk_i = 1'b0;
  always #5 src_clk_i = ~src_clk_i;

  task automatic cycle();
    @(posedge src_clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    up_valid_i = 1'b0;
    up_write_i = 1'b0;
    up_addr_i  = '0;
    up_wdata_i = '0;
    up_wstrb_i = '0;
    dn_rdata_i = '0;
    dn_error_i = 1'b0;
    dn_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    src_rst_ni = 1'b0;
    #3;
    n_total++;
    if (dn_valid_o !== 1'b0) $display("[TB] FAIL reset_dn_valid: got %b want 0", dn_valid_o);
    else n_pass++;
    n_total++;
    if (up_ready_o !== 1'b0) $display("[TB] FAIL reset_up_ready: got %b want 0", up_ready_o);
    else n_pass++;
    n_total++;
    if (timeout_o !== 1'b0) $display("[TB] FAIL reset_timeout: got %b want 0", timeout_o);
    else n_pass++;
    cycle();
    cycle();
    #2;
    src_rst_ni = 1'b1;
    cycle();
  endtask

  task automatic test_read_pass();
    up_valid_i = 1'b1;
    up_addr_i  = 32'h4;
    dn_ready_i = 1'b1;
    dn_rdata_i = 32'h1234_5678;
    #4;
    n_total++;
    if (up_ready_o !== 1'b1) $display("[TB] FAIL pass_ready: got %b want 1", up_ready_o);
    else n_pass++;
    n_total++;
    if (up_rdata_o !== 32'h1234_5678) $display("[TB] FAIL pass_rdata: got %h want 12345678", up_rdata_o);
    else n_pass++;
    n_total++;
    if (up_error_o !== 1'b0) $display("[TB] FAIL pass_error: got %b want 0", up_error_o);
    else n_pass++;
    n_total++;
    if (timeout_o !== 1'b0) $display("[TB] FAIL pass_timeout: got %b want 0", timeout_o);
    else n_pass++;
    n_total++;
    if (dn_valid_o !== 1'b1 || dn_addr_o !== 32'h4)
      $display("[TB] FAIL pass_dn_req: got valid %b addr %h want 1 00000004", dn_valid_o, dn_addr_o);
    else n_pass++;
    cycle();
    idle_inputs();
    cycle();
  endtask

  task automatic test_timeout();
    up_valid_i = 1'b1;
    up_addr_i  = 32'h40;
    for (int k = 1; k <= TO; k++) begin
      #4;
      if (k < TO) begin
        n_total++;
        if (up_ready_o !== 1'b0 || timeout_o !== 1'b0)
          $display("[TB] FAIL to_wait_%0d: got ready %b timeout %b want 0 0", k, up_ready_o, timeout_o);
        else n_pass++;
      end else begin
        n_total++;
        if (up_ready_o !== 1'b1 || up_error_o !== 1'b1 || timeout_o !== 1'b1)
          $display("[TB] FAIL to_fire: got ready %b error %b timeout %b want 1 1 1", up_ready_o, up_error_o, timeout_o);
        else n_pass++;
        n_total++;
        if (up_rdata_o !== 32'hBADCAB1E) $display("[TB] FAIL to_rdata: got %h want badcab1e", up_rdata_o);
        else n_pass++;
      end
      cycle();
    end
    up_valid_i = 1'b0;
    up_addr_i  = 32'h99;
    #4;
    n_total++;
    if (dn_valid_o !== 1'b1 || dn_addr_o !== 32'h40)
      $display("[TB] FAIL drain_hold: got valid %b addr %h want 1 00000040", dn_valid_o, dn_addr_o);
    else n_pass++;
    n_total++;
    if (up_ready_o !== 1'b0 || timeout_o !== 1'b0)
      $display("[TB] FAIL drain_quiet: got ready %b timeout %b want 0 0", up_ready_o, timeout_o);
    else n_pass++;
    cycle();
  endtask

  task automatic test_drain_new_write();
    up_valid_i = 1'b1;
    up_write_i = 1'b1;
    up_addr_i  = 32'h80;
    up_wdata_i = 32'hCAFE_0001;
    up_wstrb_i = 4'hF;
    for (int k = 1; k < 10; k++) begin
      #4;
      n_total++;
      if (dn_addr_o !== 32'h40 || dn_write_o !== 1'b0 || up_ready_o !== 1'b0)
        $display("[TB] FAIL drain_stall_%0d: got addr %h write %b ready %b want 00000040 0 0", k, dn_addr_o, dn_write_o, up_ready_o);
      else n_pass++;
      cycle();
    end
    dn_ready_i = 1'b1;
    dn_rdata_i = 32'h0000_FFFF;
    #4;
    n_total++;
    if (up_ready_o !== 1'b0 || up_rdata_o === 32'h0000_FFFF || timeout_o !== 1'b0)
      $display("[TB] FAIL drain_discard: got ready %b rdata %h timeout %b want 0 not-0000ffff 0", up_ready_o, up_rdata_o, timeout_o);
    else n_pass++;
    cycle();
    dn_rdata_i = 32'h0;
    #4;
    n_total++;
    if (dn_addr_o !== 32'h80 || dn_write_o !== 1'b1 || dn_wdata_o !== 32'hCAFE_0001 || dn_wstrb_o !== 4'hF)
      $display("[TB] FAIL fwd_after_drain: got addr %h write %b wdata %h wstrb %h want 00000080 1 cafe0001 f", dn_addr_o, dn_write_o, dn_wdata_o, dn_wstrb_o);
    else n_pass++;
    n_total++;
    if (up_ready_o !== 1'b1 || up_error_o !== 1'b0 || timeout_o !== 1'b0)
      $display("[TB] FAIL write_complete: got ready %b error %b timeout %b want 1 0 0", up_ready_o, up_error_o, timeout_o);
    else n_pass++;
    cycle();
    idle_inputs();
    cycle();
  endtask

  task automatic test_ready_at_boundary();
    up_valid_i = 1'b1;
    up_addr_i  = 32'h50;
    for (int k = 1; k < TO; k++) begin
      cycle();
    end
    dn_ready_i = 1'b1;
    dn_rdata_i = 32'hA5A5_A5A5;
    #4;
    n_total++;
    if (up_ready_o !== 1'b1 || up_error_o !== 1'b0 || timeout_o !== 1'b0)
      $display("[TB] FAIL edge_ready: got ready %b error %b timeout %b want 1 0 0", up_ready_o, up_error_o, timeout_o);
    else n_pass++;
    n_total++;
    if (up_rdata_o !== 32'hA5A5_A5A5) $display("[TB] FAIL edge_rdata: got %h want a5a5a5a5", up_rdata_o);
    else n_pass++;
    cycle();
    idle_inputs();
    #4;
    n_total++;
    if (dn_valid_o !== 1'b0) $display("[TB] FAIL edge_state_fwd: got dn_valid %b want 0", dn_valid_o);
    else n_pass++;
    cycle();
  endtask

  task automatic test_reset_in_drain();
    up_valid_i = 1'b1;
    up_addr_i  = 32'h60;
    for (int k = 1; k <= TO; k++) begin
      cycle();
    end
    idle_inputs();
    #2;
    n_total++;
    if (dn_valid_o !== 1'b1) $display("[TB] FAIL rst_pre_drain: got dn_valid %b want 1", dn_valid_o);
    else n_pass++;
    src_rst_ni = 1'b0;
    #1;
    n_total++;
    if (dn_valid_o !== 1'b0) $display("[TB] FAIL rst_async_clear: got dn_valid %b want 0", dn_valid_o);
    else n_pass++;
    #1;
    src_rst_ni = 1'b1;
    cycle();
    up_valid_i = 1'b1;
    up_addr_i  = 32'h70;
    for (int k = 1; k <= TO; k++) begin
      #4;
      n_total++;
      if (timeout_o !== (k == TO))
        $display("[TB] FAIL rst_budget_%0d: got timeout %b want %b", k, timeout_o, (k == TO));
      else n_pass++;
      n_total++;
      if (dn_addr_o !== 32'h70) $display("[TB] FAIL rst_fwd_addr_%0d: got %h want 00000070", k, dn_addr_o);
      else n_pass++;
      cycle();
    end
    idle_inputs();
    dn_ready_i = 1'b1;
    cycle();
    idle_inputs();
    cycle();
  endtask

`ifdef REG_TIMEOUT_STATUS_EN
  task automatic test_status();
    logic [AW-1:0] addrs [3];
    addrs[0] = 32'h10;
    addrs[1] = 32'h20;
    addrs[2] = 32'h30;
    idle_inputs();
    #2;
    src_rst_ni = 1'b0;
    #1;
    n_total++;
    if (timeout_cnt_o !== 16'd0 || timeout_addr_o !== '0)
      $display("[TB] FAIL status_reset: got cnt %0d addr %h want 0 00000000", timeout_cnt_o, timeout_addr_o);
    else n_pass++;
    #1;
    src_rst_ni = 1'b1;
    cycle();
    for (int t = 0; t < 3; t++) begin
      up_valid_i = 1'b1;
      up_addr_i  = addrs[t];
      for (int k = 1; k <= TO; k++) begin
        cycle();
      end
      idle_inputs();
      dn_ready_i = 1'b1;
      cycle();
      idle_inputs();
    end
    #4;
    n_total++;
    if (timeout_cnt_o !== 16'd3) $display("[TB] FAIL status_cnt: got %0d want 3", timeout_cnt_o);
    else n_pass++;
    n_total++;
    if (timeout_addr_o !== 32'h30) $display("[TB] FAIL status_addr: got %h want 00000030", timeout_addr_o);
    else n_pass++;
    cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_read_pass();
    test_timeout();
    test_drain_new_write();
    test_ready_at_boundary();
    test_reset_in_drain();
`ifdef REG_TIMEOUT_STATUS_EN
    test_status();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_timeout_src.md
Name: reg_timeout_src

Overview:
- Register-bus watchdog in the source clock domain, placed directly upstream of the register-bus CDC source side.
- Forwards requests combinationally with zero added latency.
- If the downstream (clock-crossed) target does not respond within TIMEOUT cycles, it completes the upstream transaction with an error and a fixed read pattern.
- It then holds the orphaned request until the late downstream response arrives, and discards that response.
- The upstream master never hangs on a stopped or slow destination clock.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- TIMEOUT, 256, cycles without ready before error completion; must be ≥ 2.
- ERR_RDATA, 32'hBADCAB1E, rdata returned on a timeout; zero-extended or truncated to DW.

Ports:
- src_clk_i  in  1  source clock.
- src_rst_ni  in  1  reset; asynchronous, active-low.
- up_valid_i  in  1  upstream request valid; held until up_ready_o.
- up_write_i  in  1  upstream write enable.
- up_addr_i  in  AW  upstream address.
- up_wdata_i  in  DW  upstream write data.
- up_wstrb_i  in  DW/8  upstream byte strobes.
- up_rdata_o  out  DW  upstream read data.
- up_error_o  out  1  upstream error.
- up_ready_o  out  1  upstream completion, one cycle per transaction.
- dn_valid_o  out  1  downstream (CDC) request valid.
- dn_write_o  out  1  downstream write.
- dn_addr_o  out  AW  downstream address.
- dn_wdata_o  out  DW  downstream write data.
- dn_wstrb_o  out  DW/8  downstream strobes.
- dn_rdata_i  in  DW  downstream read data.
- dn_error_i  in  1  downstream error.
- dn_ready_i  in  1  downstream completion.
- timeout_o  out  1  one-cycle pulse on each timeout completion.

Behaviour:
- States: FWD (reset state), DRAIN.
- Counter cnt, width $clog2(TIMEOUT+1), reset 0.
- Reset values: FWD, cnt = 0, hold registers = 0. All outputs derive from these, so dn_valid_o = 0 if up_valid_i = 0, and up_ready_o = 0, timeout_o = 0.

FWD:
- dn_* = up_* combinationally; up_rdata_o/up_error_o/up_ready_o = dn_* combinationally.
- cnt: cleared when !up_valid_i or dn_ready_i; incremented when up_valid_i & !dn_ready_i.
- Timeout condition: up_valid_i & !dn_ready_i & cnt == TIMEOUT-1, i.e. the TIMEOUT-th waiting cycle. On timeout:
  - up_ready_o = 1, up_error_o = 1, up_rdata_o = ERR_RDATA, timeout_o = 1.
  - Latch write/addr/wdata/wstrb into hold registers; cnt <= 0; go to DRAIN.
- Simultaneous dn_ready_i and timeout condition: the ready wins. The normal response is passed through, no timeout, and the state stays FWD.

DRAIN:
- dn_valid_o = 1 and dn_* driven from the hold registers (stable request, protocol-compliant).
- up_ready_o = 0; the upstream request is stalled (not forwarded), and cnt stays 0.
- On dn_ready_i: discard dn_rdata_i/dn_error_i and go to FWD.
- The next request is forwarded the cycle after the drain completes. dn_valid_o may stay high across that boundary only if up_valid_i is high (a new transaction).
- There is no timeout in DRAIN; a dead destination stalls further accesses but never hangs an accepted one.

Other rules:
- Asynchronous reset mid-DRAIN or mid-count returns to FWD with cnt = 0. The late response is not tracked; the downstream CDC shares this reset.
- A write that times out may still take effect downstream; an error is reported regardless.

Optional Feature:
- Macro: REG_TIMEOUT_STATUS_EN.
- Defined: adds the following outputs, both reset 0:
  - timeout_cnt_o [15:0]: saturating count of timeouts; increments on timeout_o, sticks at 16'hFFFF.
  - timeout_addr_o [AW-1:0]: address of the most recent timed-out request, captured with the hold registers.
- Undefined: these ports are absent and no extra registers are built. Core behaviour is identical either way.

Decomposition:
- Package reg_timeout_pkg:
  - state_e enum {FWD, DRAIN};
  - default ERR_RDATA constant;
  - helper function for counter width.
- One natural sub-module: reg_timeout_hold, a request hold register bank with load enable and reset clear, reused for timeout_addr_o capture. The FSM and counter stay inline.

Test Plan:
- Read, dn_ready_i asserted the same cycle as up_valid_i, dn_rdata_i = 32'h1234_5678 → up_ready_o in the same cycle, rdata 32'h1234_5678, error 0, timeout_o never asserted.
- TIMEOUT = 4, read to 0x40, dn_ready_i never asserted → up_ready_o/error/timeout_o high on the 4th valid cycle, rdata 32'hBADCAB1E. dn_valid_o stays high with addr 0x40 in DRAIN.
- In DRAIN, new upstream write to 0x80 while dn_ready_i arrives 10 cycles later with rdata 32'hFFFF → response discarded; the 0x80 write is forwarded the next cycle and completes normally.
- TIMEOUT = 4, dn_ready_i asserted exactly on the 4th waiting cycle → normal response, no error, no timeout_o, state FWD.
- Reset pulsed during DRAIN → after release dn_valid_o follows up_valid_i, cnt = 0, a fresh request gets the full TIMEOUT budget.
- With REG_TIMEOUT_STATUS_EN defined: 3 consecutive timeouts at addresses 0x10, 0x20, 0x30 → timeout_cnt_o = 3, timeout_addr_o = 0x30.
